// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: one-hot controller states,
// outcome-pulse bundle and default frame/idle/oversampling constants.
// Imported by uart_sync and uart_rx_ctrl.
package uart_pkg;

  localparam int FRAME_TICKS_DEF = 192;  // 16x oversampling * 12 bit times
  localparam int IDLE_TICKS_DEF  = 16;   // one bit time of quiet line
  localparam int OVERSAMPLE_DEF  = 16;

  // Idle level of an asynchronous serial line.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_ARM     = 6'b000010,
    ST_START   = 6'b000100,
    ST_WAIT    = 6'b001000,
    ST_CAPTURE = 6'b010000,
    ST_RECOVER = 6'b100000
  } state_e;

  // Registered rising-edge pulses of the receiver status flags.
  typedef struct packed {
    logic done;
    logic perr;
    logic ferr;
  } outcome_t;

endpackage

// File: rtl/uart_sync.sv
// Serial pad synchroniser with a registered falling-edge detector.
// Ports: clk, rst_n, rx_pin (async pad) -> rx_sync (pin delayed SYNC_STAGES
// clocks, resets to idle-high), fall (one-cycle pulse, one clock after rx_sync drops).
module uart_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_pin};
    prev_d = sync_q[SYNC_STAGES-1];
    fall_d = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
      prev_q <= LINE_IDLE;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign fall    = fall_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the pad, fires rx_start on a start edge,
// watches the frame with a tick watchdog and delivers bytes on valid/ready with
// sticky error status. Ports: pad/tick/enable in; receiver handshake
// (rx_start out, rx_done/rx_busy/error flags/rx_dout in); byte stream
// (m_data/m_valid out, m_ready in); status (clr_status in, sticky flags and
// ctrl_busy out). Optional UART_RX_ERR_CNT_EN adds saturating error counters.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WD     = 8,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int IDLE_TICKS  = IDLE_TICKS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               rx_pin,
  input  logic               tick,
  output logic               rx_sync,
  output logic               rx_start,
  input  logic               rx_done,
  input  logic               rx_busy,
  input  logic               parity_error_flag,
  input  logic               framing_error_flag,
  input  logic [DATA_WD-1:0] rx_dout,
  output logic [DATA_WD-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  input  logic               clr_status,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun,
  output logic               timeout,
`ifdef UART_RX_ERR_CNT_EN
  output logic [15:0]        frame_err_cnt,
  output logic [15:0]        parity_err_cnt,
  output logic [7:0]         timeout_cnt,
`endif
  output logic               ctrl_busy
);

  localparam int WD_W = $clog2(FRAME_TICKS + 1);
  localparam int ID_W = $clog2(IDLE_TICKS + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(FRAME_TICKS);
  localparam logic [ID_W-1:0] ID_LIM = ID_W'(IDLE_TICKS);

  logic fall;

  state_e             state_q, state_d;
  logic               rx_start_q, rx_start_d;
  logic               done_prev_q, perr_prev_q, ferr_prev_q;
  outcome_t           rise_q, rise_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [ID_W-1:0]    idle_q, idle_d;
  logic [DATA_WD-1:0] m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic set_perr, set_ferr, set_to, set_ovr, load;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_sync(rx_sync),
    .fall   (fall)
  );

  // Receiver flags are levels; only their rising edges count as outcomes.
  always_comb begin
    rise_d.done = rx_done & ~done_prev_q;
    rise_d.perr = parity_error_flag & ~perr_prev_q;
    rise_d.ferr = framing_error_flag & ~ferr_prev_q;
  end

  // Watchdog runs only in WAIT; every other state (START included) clears it.
  always_comb begin
    wd_d = '0;
    if (state_q == ST_WAIT) begin
      wd_d = wd_q;
      if (tick && (wd_q != WD_LIM)) wd_d = wd_q + WD_W'(1);
    end
  end

  // Quiet-line counter: any low tick restarts the count.
  always_comb begin
    idle_d = '0;
    if (state_q == ST_RECOVER) begin
      idle_d = idle_q;
      if (tick) begin
        if (!rx_sync)             idle_d = '0;
        else if (idle_q != ID_LIM) idle_d = idle_q + ID_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    set_to   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (fall)         state_d = ST_START;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Errors outrank done so a corrupt byte is never delivered; any
        // outcome outranks the watchdog. enable is deliberately ignored here.
        if (rise_q.perr || rise_q.ferr) begin
          set_perr = rise_q.perr;
          set_ferr = rise_q.ferr;
          state_d  = ST_RECOVER;
        end else if (rise_q.done) begin
          state_d = ST_CAPTURE;
        end else if (wd_d == WD_LIM) begin
          set_to  = 1'b1;
          state_d = ST_RECOVER;
        end
      end
      ST_CAPTURE: begin
        load    = 1'b1;
        state_d = enable ? ST_ARM : ST_IDLE;
      end
      ST_RECOVER: begin
        // Do not re-arm into a receiver that is still shifting a frame.
        if ((idle_d == ID_LIM) && !rx_busy) state_d = enable ? ST_ARM : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rx_start_d = (state_d == ST_START);
  end

  // Holding register: a load may replace a byte only in its handshake cycle.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    set_ovr   = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (load) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = rx_dout;
        m_valid_d = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end
  end

  // Sticky flags: a set in the clearing cycle survives.
  always_comb begin
    frame_err_d  = set_ferr | (frame_err_q  & ~clr_status);
    parity_err_d = set_perr | (parity_err_q & ~clr_status);
    overrun_d    = set_ovr  | (overrun_q    & ~clr_status);
    timeout_d    = set_to   | (timeout_q    & ~clr_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_start_q   <= 1'b0;
      done_prev_q  <= 1'b0;
      perr_prev_q  <= 1'b0;
      ferr_prev_q  <= 1'b0;
      rise_q       <= '0;
      wd_q         <= '0;
      idle_q       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_start_q   <= rx_start_d;
      done_prev_q  <= rx_done;
      perr_prev_q  <= parity_error_flag;
      ferr_prev_q  <= framing_error_flag;
      rise_q       <= rise_d;
      wd_q         <= wd_d;
      idle_q       <= idle_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] fe_cnt_q, fe_cnt_d;
  logic [15:0] pe_cnt_q, pe_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  // Clear first, then count, so an event in the clearing cycle reads as 1.
  always_comb begin
    fe_cnt_d = clr_status ? '0 : fe_cnt_q;
    pe_cnt_d = clr_status ? '0 : pe_cnt_q;
    to_cnt_d = clr_status ? '0 : to_cnt_q;
    if (set_ferr && (fe_cnt_d != '1)) fe_cnt_d = fe_cnt_d + 16'd1;
    if (set_perr && (pe_cnt_d != '1)) pe_cnt_d = pe_cnt_d + 16'd1;
    if (set_to   && (to_cnt_d != '1)) to_cnt_d = to_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_cnt_q <= '0;
      pe_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      fe_cnt_q <= fe_cnt_d;
      pe_cnt_q <= pe_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign frame_err_cnt  = fe_cnt_q;
  assign parity_err_cnt = pe_cnt_q;
  assign timeout_cnt    = to_cnt_q;
`else
  // Counters absent: the sticky flags alone report errors.
`endif

  assign rx_start   = rx_start_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign ctrl_busy  = !((state_q == ST_IDLE) || (state_q == ST_ARM));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl; the bench plays the receiver and the
// byte consumer. Frame outcomes run from a vector table, then directed
// sequences cover overrun, watchdog timeout, clear-vs-set and async reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, rx_pin, tick;
  logic       rx_sync, rx_start;
  logic       rx_done, rx_busy, parity_error_flag, framing_error_flag;
  logic [7:0] rx_dout, m_data;
  logic       m_valid, m_ready, clr_status;
  logic       frame_err, parity_err, overrun, timeout, ctrl_busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] frame_err_cnt, parity_err_cnt;
  logic [7:0]  timeout_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .rx_pin            (rx_pin),
    .tick              (tick),
    .rx_sync           (rx_sync),
    .rx_start          (rx_start),
    .rx_done           (rx_done),
    .rx_busy           (rx_busy),
    .parity_error_flag (parity_error_flag),
    .framing_error_flag(framing_error_flag),
    .rx_dout           (rx_dout),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .clr_status        (clr_status),
    .frame_err         (frame_err),
    .parity_err        (parity_err),
    .overrun           (overrun),
    .timeout           (timeout),
`ifdef UART_RX_ERR_CNT_EN
    .frame_err_cnt     (frame_err_cnt),
    .parity_err_cnt    (parity_err_cnt),
    .timeout_cnt       (timeout_cnt),
`endif
    .ctrl_busy         (ctrl_busy)
  );

  always #5 clk = ~clk;

  // kind: 0 good, 1 parity, 2 framing, 3 both errors, 4 done with parity error
  typedef struct {
    logic [7:0] dout;
    int         kind;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_busy;
    logic       exp_valid_next;
  } vec_t;

  vec_t vecs[7];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
  endtask

  // Pin captured at the next edge N; rx_start must be high only in cycle N+3.
  task automatic frame_start(input logic hold_low);
    rx_pin = 1'b0;
    cyc(3);
    check("rx_start_early", 32'(rx_start), 32'd0);
    cyc(1);
    check("rx_start_pulse", 32'(rx_start), 32'd1);
    cyc(1);
    check("rx_start_end", 32'(rx_start), 32'd0);
    check("busy_in_wait", 32'(ctrl_busy), 32'd1);
    if (!hold_low) rx_pin = 1'b1;
  endtask

  // Returns two edges after raising the flags: state is CAPTURE or RECOVER.
  task automatic outcome(input int kind, input logic [7:0] d, input logic clr_at_set);
    rx_dout            = d;
    rx_done            = (kind == 0) || (kind == 4);
    parity_error_flag  = (kind == 1) || (kind == 3) || (kind == 4);
    framing_error_flag = (kind == 2) || (kind == 3);
    cyc(1);
    if (clr_at_set) clr_status = 1'b1;
    cyc(1);
    clr_status         = 1'b0;
    rx_done            = 1'b0;
    parity_error_flag  = 1'b0;
    framing_error_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic saw_start;
    vecs[0] = '{8'hA5, 0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 2, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h66, 3, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h77, 4, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; enable = 1'b0; rx_pin = 1'b1; tick = 1'b0;
    rx_done = 1'b0; rx_busy = 1'b0; parity_error_flag = 1'b0; framing_error_flag = 1'b0;
    rx_dout = 8'h00; m_ready = 1'b0; clr_status = 1'b0;

    #12;
    check("rst_rx_sync", 32'(rx_sync), 32'd1);
    check("rst_rx_start", 32'(rx_start), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_flags", 32'({frame_err, parity_err, overrun, timeout}), 32'd0);
    check("rst_busy", 32'(ctrl_busy), 32'd0);

    @(posedge clk); #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(2);

    // Table: one frame per entry, status cleared first.
    for (int i = 0; i < 7; i++) begin
      clear_status();
      m_ready = vecs[i].rdy;
      frame_start(1'b0);
      do_tick(5);
      outcome(vecs[i].kind, vecs[i].dout, 1'b0);
      cyc(1);
      check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      check($sformatf("v%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(ctrl_busy), 32'(vecs[i].exp_busy));
      cyc(1);
      check($sformatf("v%0d_m_valid_next", i), 32'(m_valid), 32'(vecs[i].exp_valid_next));
      if (vecs[i].kind != 0) begin
        do_tick(15);
        check($sformatf("v%0d_recover_15", i), 32'(ctrl_busy), 32'd1);
        do_tick(1);
        check($sformatf("v%0d_recover_16", i), 32'(ctrl_busy), 32'd0);
      end
      m_ready = 1'b1;
      cyc(2);
    end

    // Overrun, then a load in the handshake cycle replaces the held byte.
    clear_status();
    m_ready = 1'b0;
    frame_start(1'b0);
    outcome(0, 8'h01, 1'b0);
    cyc(1);
    check("ovr_first_data", 32'(m_data), 32'h01);
    check("ovr_first_flag", 32'(overrun), 32'd0);
    frame_start(1'b0);
    outcome(0, 8'h02, 1'b0);
    cyc(1);
    check("ovr_held_data", 32'(m_data), 32'h01);
    check("ovr_set", 32'(overrun), 32'd1);
    frame_start(1'b0);
    outcome(0, 8'h03, 1'b0);
    m_ready = 1'b1;
    cyc(1);
    check("ovr_swap_data", 32'(m_data), 32'h03);
    check("ovr_swap_valid", 32'(m_valid), 32'd1);
    check("ovr_unchanged", 32'(overrun), 32'd1);
    cyc(1);
    check("ovr_drained", 32'(m_valid), 32'd0);

    // Watchdog: receiver never reports; line stays low afterwards.
    clear_status();
    frame_start(1'b1);
    do_tick(191);
    check("to_tick191", 32'(timeout), 32'd0);
    do_tick(1);
    check("to_tick192", 32'(timeout), 32'd1);
`ifdef UART_RX_ERR_CNT_EN
    check("to_cnt", 32'(timeout_cnt), 32'd1);
`endif
    do_tick(20);
    check("to_low_line_busy", 32'(ctrl_busy), 32'd1);
    rx_pin = 1'b1;
    cyc(3);
    do_tick(15);
    check("to_recover_15", 32'(ctrl_busy), 32'd1);
    do_tick(1);
    check("to_recover_16", 32'(ctrl_busy), 32'd0);
    check("to_no_byte", 32'(m_valid), 32'd0);
    check("to_sticky", 32'(timeout), 32'd1);

    // Framing error sets in the same cycle clr_status is high.
    clear_status();
    check("clr_frame_err_pre", 32'(frame_err), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("clr_cnt_pre", 32'(frame_err_cnt), 32'd0);
`endif
    frame_start(1'b0);
    do_tick(3);
    outcome(2, 8'h00, 1'b1);
    check("clr_set_wins", 32'(frame_err), 32'd1);
    check("clr_cleared_timeout", 32'(timeout), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("clr_cnt_post", 32'(frame_err_cnt), 32'd1);
`endif
    do_tick(16);
    clear_status();
    check("clr_frame_err_cleared", 32'(frame_err), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    m_ready = 1'b0;
    frame_start(1'b0);
    outcome(0, 8'h42, 1'b0);
    frame_start(1'b0);
    outcome(0, 8'h43, 1'b0);
    cyc(1);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    frame_start(1'b0);
    do_tick(2);
    rx_pin = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_rx_sync", 32'(rx_sync), 32'd1);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_m_data", 32'(m_data), 32'd0);
    check("arst_flags", 32'({frame_err, parity_err, overrun, timeout}), 32'd0);
    check("arst_busy", 32'(ctrl_busy), 32'd0);
    enable = 1'b0;
    rx_pin = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3);
    rx_pin = 1'b0;
    saw_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (rx_start) saw_start = 1'b1;
    end
    check("disabled_no_start", 32'(saw_start), 32'd0);
    check("disabled_idle", 32'(ctrl_busy), 32'd0);
    rx_pin = 1'b1;
    cyc(4);
    enable = 1'b1;
    cyc(1);
    frame_start(1'b0);
    do_tick(2);
    m_ready = 1'b1;
    outcome(0, 8'h5C, 1'b0);
    cyc(1);
    check("post_rst_valid", 32'(m_valid), 32'd1);
    check("post_rst_data", 32'(m_data), 32'h5C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
